// File: rtl/demux_16_deser_if.sv
// Bus bundle for the 16-bit serial-to-parallel demux deserializer.
// The master drives frame start, serial data and consumer ready.
// The slave (the deserializer) returns the assembled word and its status.
interface demux_16_deser_if;
    logic        start;
    logic        din;
    logic        din_valid;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [3:0]  sel;
    logic        busy;
    logic        err;

    modport master (
        output start,
        output din,
        output din_valid,
        output dout_ready,
        input  dout,
        input  dout_valid,
        input  sel,
        input  busy,
        input  err
    );

    modport slave (
        input  start,
        input  din,
        input  din_valid,
        input  dout_ready,
        output dout,
        output dout_valid,
        output sel,
        output busy,
        output err
    );
endinterface

// File: rtl/demux_16_deser.sv
// 16:1 demux deserializer.
// Each accepted serial bit is written into shadow[sel], and sel then steps
// towards the far end of the word. The 16th accept publishes the whole
// shadow word on dout and holds it until the consumer takes it.
// Bits that arrive while a word is still held are dropped and flagged on err.
module demux_16_deser #(
    parameter bit MSB_FIRST = 1'b0
) (
    input logic              clk,
    input logic              rst,
    demux_16_deser_if.slave  bus
);

    // Index of the first bit written and of the 16th bit written.
    localparam logic [3:0] SelFirst = MSB_FIRST ? 4'd15 : 4'd0;
    localparam logic [3:0] SelLast  = MSB_FIRST ? 4'd0  : 4'd15;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StHold
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] dout_q, dout_d;
    logic        dout_valid_q, dout_valid_d;
    logic        err_q, err_d;

    // Next index after an accept; wraps only via the explicit SelLast check.
    logic [3:0]  sel_step;

    assign sel_step = MSB_FIRST ? (sel_q - 4'd1) : (sel_q + 4'd1);

    // Next-state logic: frame control, bit capture, word publish and overrun detection.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        err_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                // The start cycle never captures din, even if it is qualified.
                if (bus.start) begin
                    state_d  = StRecv;
                    sel_d    = SelFirst;
                    shadow_d = 16'h0000;
                end
            end

            StRecv: begin
                if (bus.start) begin
                    // Restart discards the partial frame; start beats din_valid.
                    sel_d    = SelFirst;
                    shadow_d = 16'h0000;
                end else if (bus.din_valid) begin
                    shadow_d[sel_q] = bus.din;
                    if (sel_q == SelLast) begin
                        dout_d       = shadow_d;
                        dout_valid_d = 1'b1;
                        sel_d        = SelFirst;
                        state_d      = StHold;
                    end else begin
                        sel_d = sel_step;
                    end
                end
            end

            StHold: begin
                if (bus.dout_ready) begin
                    dout_valid_d = 1'b0;
                    if (bus.start) begin
                        state_d  = StRecv;
                        sel_d    = SelFirst;
                        shadow_d = 16'h0000;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (bus.din_valid) begin
                    // No room for the bit: drop it and flag an overrun.
                    err_d = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset clears all frame data immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            sel_q        <= SelFirst;
            shadow_q     <= 16'h0000;
            dout_q       <= 16'h0000;
            dout_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            err_q        <= err_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.sel        = sel_q;
    assign bus.busy       = (state_q == StRecv);
    assign bus.err        = err_q;

    // A held word is never overwritten before the consumer accepts it.
    a_dout_stable: assert property (@(posedge clk) disable iff (rst)
        (dout_valid_q && !bus.dout_ready) |=> (dout_valid_q && $stable(dout_q)));

    // err is a single-cycle pulse.
    a_err_pulse: assert property (@(posedge clk) disable iff (rst)
        err_q |=> !err_q);

    // dout_valid is high exactly while holding a word.
    a_valid_hold: assert property (@(posedge clk) disable iff (rst)
        dout_valid_q == (state_q == StHold));

endmodule

// File: tb/tb_demux_16_deser.sv
// Bench for demux_16_deser: one LSB-first and one MSB-first instance share
// control inputs. Each is fed the bit order that rebuilds the same word, so
// both scoreboards expect identical frames.
module tb_demux_16_deser;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic start;
    logic din0;
    logic din1;
    logic din_valid;
    logic dout_ready;

    demux_16_deser_if bus0 ();
    demux_16_deser_if bus1 ();

    assign bus0.start      = start;
    assign bus0.din        = din0;
    assign bus0.din_valid  = din_valid;
    assign bus0.dout_ready = dout_ready;
    assign bus1.start      = start;
    assign bus1.din        = din1;
    assign bus1.din_valid  = din_valid;
    assign bus1.dout_ready = dout_ready;

    demux_16_deser #(.MSB_FIRST(1'b0)) u_dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    demux_16_deser #(.MSB_FIRST(1'b1)) u_dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          err_cnt0 = 0;
    int          err_cnt1 = 0;
    logic        vprev0   = 1'b0;
    logic        vprev1   = 1'b0;
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [31:0] e0;
    logic [31:0] e1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Scoreboard pop on each new word; an empty queue yields an impossible value.
    always @(negedge clk) begin
        if (rst) begin
            vprev0 <= 1'b0;
            vprev1 <= 1'b0;
        end else begin
            if (bus0.dout_valid && !vprev0) begin
                e0 = (exp_q0.size() != 0) ? {16'h0, exp_q0.pop_front()} : 32'hDEAD_0000;
                check_eq("sb_lsb_dout", {16'h0, bus0.dout}, e0);
            end
            if (bus1.dout_valid && !vprev1) begin
                e1 = (exp_q1.size() != 0) ? {16'h0, exp_q1.pop_front()} : 32'hDEAD_0000;
                check_eq("sb_msb_dout", {16'h0, bus1.dout}, e1);
            end
            if (bus0.err) err_cnt0 <= err_cnt0 + 1;
            if (bus1.err) err_cnt1 <= err_cnt1 + 1;
            vprev0 <= bus0.dout_valid;
            vprev1 <= bus1.dout_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start pulse with a qualified bit that must not be captured.
    task automatic do_start();
        start     = 1'b1;
        din_valid = 1'b1;
        din0      = 1'b1;
        din1      = 1'b1;
        tick();
        start     = 1'b0;
        din_valid = 1'b0;
        check_eq("start_busy0", bus0.busy, 1);
        check_eq("start_busy1", bus1.busy, 1);
        check_eq("start_sel0", bus0.sel, 0);
        check_eq("start_sel1", bus1.sel, 15);
    endtask

    task automatic drive_bit(input logic [15:0] w, input int i);
        check_eq("sel0", bus0.sel, i);
        check_eq("sel1", bus1.sel, 15 - i);
        din0      = w[i];
        din1      = w[15 - i];
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] w, input int nbits, input int max_gap);
        for (int i = 0; i < nbits; i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                din0 = ~w[i];
                din1 = ~w[15 - i];
                tick();
            end
            if (i == 15) check_eq("early_valid0", bus0.dout_valid, 0);
            drive_bit(w, i);
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input int max_gap);
        exp_q0.push_back(w);
        exp_q1.push_back(w);
        send_bits(w, 16, max_gap);
        check_eq("lat_valid0", bus0.dout_valid, 1);
        check_eq("lat_valid1", bus1.dout_valid, 1);
        check_eq("frame_dout0", bus0.dout, w);
        check_eq("frame_dout1", bus1.dout, w);
        check_eq("wrap_sel0", bus0.sel, 0);
        check_eq("wrap_sel1", bus1.sel, 15);
        check_eq("hold_busy0", bus0.busy, 0);
    endtask

    task automatic release_word();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check_eq("rel_valid0", bus0.dout_valid, 0);
        check_eq("rel_valid1", bus1.dout_valid, 0);
        check_eq("rel_busy0", bus0.busy, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_dout0"}, bus0.dout, 0);
        check_eq({tag, "_dout1"}, bus1.dout, 0);
        check_eq({tag, "_valid0"}, bus0.dout_valid, 0);
        check_eq({tag, "_busy0"}, bus0.busy, 0);
        check_eq({tag, "_busy1"}, bus1.busy, 0);
        check_eq({tag, "_err0"}, bus0.err, 0);
        check_eq({tag, "_sel0"}, bus0.sel, 0);
        check_eq({tag, "_sel1"}, bus1.sel, 15);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        din0       = 1'b0;
        din1       = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        tick();
        tick();
        check_reset_values("rst");
        rst = 1'b0;

        // Qualified bits in IDLE are ignored without err.
        din_valid = 1'b1;
        din0      = 1'b1;
        din1      = 1'b1;
        tick();
        tick();
        din_valid = 1'b0;
        check_eq("idle_busy0", bus0.busy, 0);
        check_eq("idle_err0", bus0.err, 0);
        check_eq("idle_sel0", bus0.sel, 0);

        // Consecutive frame.
        do_start();
        send_frame(16'hAAAA, 0);
        release_word();

        // Frame with random gaps.
        do_start();
        send_frame(16'hF0F0, 3);
        release_word();

        // Backpressure: overrun on cycle 3, ignored start on cycle 4.
        do_start();
        send_frame(16'h1234, 0);
        for (int c = 1; c <= 5; c++) begin
            din_valid = (c == 3);
            start     = (c == 4);
            din0      = 1'b1;
            din1      = 1'b1;
            tick();
            din_valid = 1'b0;
            start     = 1'b0;
            check_eq("bp_dout0", bus0.dout, 16'h1234);
            check_eq("bp_dout1", bus1.dout, 16'h1234);
            check_eq("bp_valid0", bus0.dout_valid, 1);
            check_eq("bp_busy0", bus0.busy, 0);
            check_eq("bp_err0", bus0.err, (c == 3));
            check_eq("bp_err1", bus1.err, (c == 3));
        end
        release_word();

        // Restart after a partial frame.
        do_start();
        send_bits(16'hFFFF, 7, 0);
        do_start();
        send_frame(16'h00FF, 0);
        release_word();

        // Asynchronous reset mid-frame.
        do_start();
        send_bits(16'hC3C3, 9, 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("arst");
        tick();
        rst = 1'b0;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        check_eq("post_rst_busy0", bus0.busy, 0);
        check_eq("post_rst_sel0", bus0.sel, 0);
        do_start();
        send_frame(16'h5A5A, 1);

        // Back-to-back: release and start in the same HOLD cycle.
        dout_ready = 1'b1;
        start      = 1'b1;
        tick();
        dout_ready = 1'b0;
        start      = 1'b0;
        check_eq("b2b_busy0", bus0.busy, 1);
        check_eq("b2b_busy1", bus1.busy, 1);
        check_eq("b2b_valid0", bus0.dout_valid, 0);
        send_frame(16'hFFFF, 0);
        release_word();

        tick();
        check_eq("err_pulses0", err_cnt0, 1);
        check_eq("err_pulses1", err_cnt1, 1);
        check_eq("sb_left0", exp_q0.size(), 0);
        check_eq("sb_left1", exp_q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/demux_16_deser.md
DEMUX_16_DESER -- requirements
Module: demux_16_deser

Interface
REQ-001 SHALL provide parameter MSB_FIRST, default 0, which selects bit order: 0 writes dout[0] first, 1 writes dout[15] first.
REQ-002 SHALL have input clk, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have input rst, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have input start, 1 bit, which begins a new 16-bit frame.
REQ-005 SHALL have input din, 1 bit, the serial data bit (the single line driven by the 16:1 mux side).
REQ-006 SHALL have input din_valid, 1 bit, which qualifies din.
REQ-007 SHALL have output dout, 16 bits, the assembled word.
REQ-008 SHALL have output dout_valid, 1 bit, indicating that dout holds a complete frame.
REQ-009 SHALL have input dout_ready, 1 bit, the consumer accept signal.
REQ-010 SHALL have output sel, 4 bits, the demux index that the next accepted bit is written to.
REQ-011 SHALL have output busy, 1 bit, high while in RECV.
REQ-012 SHALL have output err, 1 bit, a one-cycle overrun pulse.

Function
REQ-013 SHALL implement three states: IDLE, RECV and HOLD.
REQ-014 IDLE: start=1 -> RECV; sel loads 0 (MSB_FIRST=0) or 15 (MSB_FIRST=1); the shadow register clears to 0.
REQ-015 The cycle in which start is sampled SHALL NOT accept din, even if din_valid=1.
REQ-016 RECV: each cycle with din_valid=1 writes din into shadow[sel], then sel increments (MSB_FIRST=0) or decrements (MSB_FIRST=1).
REQ-017 RECV: cycles with din_valid=0 SHALL hold sel and the shadow register unchanged; gaps are unlimited.
REQ-018 The accept of the 16th bit (sel=15 for LSB-first, sel=0 for MSB-first) SHALL load dout with the full shadow value, including that bit, and transition to HOLD.
REQ-019 dout_valid SHALL be high starting the cycle after the 16th accepted bit (latency 1 cycle).
REQ-020 sel SHALL wrap to its start value on the 16th accept; no other wrap occurs.
REQ-021 HOLD: dout and dout_valid SHALL remain stable until dout_ready=1 is sampled.
REQ-022 HOLD with dout_ready=1: dout_valid clears next cycle and the state becomes IDLE, or becomes RECV if start=1 in the same cycle (REQ-014 applies).
REQ-023 HOLD with din_valid=1 and dout_ready=0: the bit SHALL be dropped and err pulses high the next cycle for one cycle.
REQ-024 HOLD with start=1 and dout_ready=0: start SHALL be ignored.
REQ-025 RECV with start=1: the partial frame SHALL be discarded and the frame restarts per REQ-014; start has priority over din_valid.
REQ-026 dout SHALL change only on entry to HOLD; it retains its last frame through IDLE and RECV.
REQ-027 busy SHALL equal (state==RECV); err SHALL be 0 in all other cases.
REQ-028 din_valid in IDLE SHALL be ignored with no err.

Reset
REQ-029 rst=1 SHALL immediately force: state IDLE, dout=16'h0000, shadow=0, dout_valid=0, busy=0, err=0, and sel=0 (MSB_FIRST=0) or 15 (MSB_FIRST=1).
REQ-030 Reset asserted mid-RECV or mid-HOLD SHALL discard all frame data; the first frame after release requires a new start.

Verification
REQ-031 MSB_FIRST=0: start, then bits of 16'hAAAA LSB-first on 16 consecutive din_valid cycles -> dout=16'hAAAA, dout_valid high exactly 1 cycle after the 16th bit, sel back at 0.
REQ-032 MSB_FIRST=1: start, then bits of 16'hF0F0 MSB-first with din_valid gaps of 0-3 cycles -> dout=16'hF0F0; sel steps 15..0 only on valid cycles.
REQ-033 Backpressure: frame 16'h1234 completes with dout_ready=0 for 5 cycles and din_valid=1 on cycle 3 -> dout stable at 16'h1234, err pulses once; dout_ready=1 -> dout_valid low next cycle.
REQ-034 Restart: 7 bits accepted, then start, then 16 bits of 16'h00FF -> dout=16'h00FF, with no residue from the partial frame.
REQ-035 Reset: rst asserted asynchronously after 9 bits -> all outputs at reset values before the next clock edge; a following full frame of 16'h5A5A -> dout=16'h5A5A.
REQ-036 Back-to-back: dout_ready=1 and start=1 in the same HOLD cycle, then frame 16'hFFFF -> direct HOLD->RECV transition, dout=16'hFFFF.
